// File: rtl/decoder_scan.sv
// Registered one-hot/one-cold decoder with a built-in up/down index scanner.
// Latency: 1 cycle from a/mode/en to idx/y/wrap. y is always registered.
// Backpressure: none. Free-running outputs; en=0 freezes state and blanks y.
//
// Ports:
//   clk, rst   single rising-edge clock, asynchronous active-high reset
//   en         1 = run and drive y, 0 = freeze idx/cnt and blank y
//   mode       00 direct, 01 scan up, 10 scan down, 11 hold
//   a          direct select value, or scan preload value
//   load       scan-mode preload strobe (idx <= a)
//   tick_div   scan step period minus 1 (0 = step every cycle)
//   y          registered one-hot output (one-cold when ACTIVE_LOW)
//   idx        current index register
//   wrap       one-cycle pulse, aligned with the first y showing a wrapped index
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      a,
  input  logic                  load,
  input  logic [DIV_W-1:0]      tick_div,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;
  localparam logic [OUT_W-1:0] Y_BLANK = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode_q;
  mode_e            mode_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             wrap_nxt;
  logic [OUT_W-1:0] y_nxt;
  logic [OUT_W-1:0] hot;
  logic             mode_chg;

  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    mode_nxt = mode_q;
    wrap_nxt = 1'b0;
    y_nxt    = Y_BLANK;
    hot      = '0;
    mode_chg = (mode_e'(mode) != mode_q);

    if (en) begin
      mode_nxt = mode_e'(mode);
      // A mode change restarts the prescaler; the step decision is skipped on
      // that edge so the first step lands tick_div+1 edges after entry.
      if (mode_chg) cnt_nxt = '0;

      case (mode_e'(mode))
        MODE_DIRECT: begin
          idx_nxt = a;
          cnt_nxt = '0;
        end
        MODE_UP, MODE_DOWN: begin
          if (load) begin
            // Preload beats a coincident terminal count: no step, no wrap.
            idx_nxt = a;
            cnt_nxt = '0;
          end else if (!mode_chg) begin
            // >= so that shrinking tick_div mid-count steps immediately.
            if (cnt >= tick_div) begin
              cnt_nxt = '0;
              if (mode_e'(mode) == MODE_UP) begin
                idx_nxt  = idx + SEL_W'(1);
                wrap_nxt = (idx == IDX_MAX);
              end else begin
                idx_nxt  = idx - SEL_W'(1);
                wrap_nxt = (idx == '0);
              end
            end else begin
              cnt_nxt = cnt + DIV_W'(1);
            end
          end
        end
        default: ; // hold: idx and cnt frozen, y keeps decoding idx
      endcase

      hot          = '0;
      hot[idx_nxt] = 1'b1;
      y_nxt        = ACTIVE_LOW ? ~hot : hot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      mode_q <= MODE_DIRECT;
      wrap   <= 1'b0;
      y      <= Y_BLANK;
    end else begin
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      wrap   <= wrap_nxt;
      y      <= y_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (8-line active-high, 16-line active-low)
// share control inputs and are checked every cycle against a behavioural model.
module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [2:0]  a0;
  logic [3:0]  a1;
  logic        load;
  logic [15:0] tick_div;
  logic [7:0]  y0;
  logic [2:0]  idx0;
  logic        wrap0;
  logic [15:0] y1;
  logic [3:0]  idx1;
  logic        wrap1;

  int n_chk  = 0;
  int n_fail = 0;

  // model state per instance (0: SEL_W=3 active-high, 1: SEL_W=4 active-low)
  int m_idx[2];
  int m_cnt[2];
  int m_mq[2];
  bit m_wrap[2];
  bit m_on[2];

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a0), .load(load),
    .tick_div(tick_div), .y(y0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.SEL_W(4), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a1), .load(load),
    .tick_div(tick_div), .y(y1), .idx(idx1), .wrap(wrap1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_y(input int d);
    logic [31:0] v;
    if (!m_on[d]) return (d == 1) ? 32'h0000_FFFF : 32'h0;
    v = 32'h1 << m_idx[d];
    return (d == 1) ? (~v & 32'h0000_FFFF) : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0; m_cnt[d] = 0; m_mq[d] = 0; m_wrap[d] = 0; m_on[d] = 0;
    end
  endtask

  // One clock edge worth of the behavioural rules, using the inputs held at the edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int  n;
      int  av;
      int  md;
      bit  chg;
      n  = (d == 1) ? 16 : 8;
      av = (d == 1) ? int'(a1) : int'(a0);
      md = int'(mode);
      m_wrap[d] = 0;
      m_on[d]   = en;
      if (en) begin
        chg = (md != m_mq[d]);
        m_mq[d] = md;
        if (chg) m_cnt[d] = 0;
        if (md == 0) begin
          m_idx[d] = av;
          m_cnt[d] = 0;
        end else if (md == 1 || md == 2) begin
          if (load) begin
            m_idx[d] = av;
            m_cnt[d] = 0;
          end else if (!chg) begin
            if (m_cnt[d] >= int'(tick_div)) begin
              m_cnt[d] = 0;
              if (md == 1) begin
                m_wrap[d] = (m_idx[d] == n - 1);
                m_idx[d]  = (m_idx[d] + 1) % n;
              end else begin
                m_wrap[d] = (m_idx[d] == 0);
                m_idx[d]  = (m_idx[d] + n - 1) % n;
              end
            end else begin
              m_cnt[d] = m_cnt[d] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("y0",    32'(y0),    exp_y(0));
    chk("idx0",  32'(idx0),  32'(m_idx[0]));
    chk("wrap0", 32'(wrap0), 32'(m_wrap[0]));
    chk("y1",    32'(y1),    exp_y(1));
    chk("idx1",  32'(idx1),  32'(m_idx[1]));
    chk("wrap1", 32'(wrap1), 32'(m_wrap[1]));
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_y0",   32'(y0),    32'h00);
    chk("rst_idx0", 32'(idx0),  32'h0);
    chk("rst_wrap", 32'(wrap0), 32'h0);
    chk("rst_y1",   32'(y1),    32'hFFFF);
    chk("rst_idx1", 32'(idx1),  32'h0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wraps;
    int p;
    logic [7:0] onehot;
    rst = 1'b1; en = 1'b1; mode = 2'b00; a0 = 3'd0; a1 = 4'd0; load = 1'b0; tick_div = 16'd0;
    model_reset();
    #12;
    rst = 1'b0;

    // direct mode, then asynchronous reset mid-cycle
    a0 = 3'd3; a1 = 4'd3;
    cycle(); cycle();
    async_reset();
    chk("rst_before_direct", 32'(y0), 32'h0);

    a0 = 3'd5; a1 = 4'd9;
    cycle();
    chk("direct_a5", 32'(y0), 32'h20);
    chk("active_low_a9", 32'(y1), 32'hFDFF);
    for (int i = 0; i < 8; i++) begin
      a0 = 3'(i); a1 = 4'(15 - i);
      cycle();
      onehot = 8'h01 << i;
      chk("sweep", 32'(y0), 32'(onehot));
    end

    // scan up, tick_div=2: step every 3 edges, one wrap landing on y=8'h01
    a0 = 3'd0; a1 = 4'd0;
    cycle();
    mode = 2'b01; tick_div = 16'd2;
    wraps = 0;
    for (int i = 1; i <= 27; i++) begin
      cycle();
      chk("up_seq", 32'(idx0), 32'(((i - 1) / 3) % 8));
      if (wrap0) begin
        wraps++;
        chk("up_wrap_y", 32'(y0), 32'h01);
      end
    end
    chk("up_wrap_count", 32'(wraps), 32'd1);

    // scan down; preload coinciding with terminal count
    mode = 2'b10;
    cycle();
    for (int i = 0; i < 10 && m_cnt[0] != 2; i++) cycle();
    load = 1'b1; a0 = 3'd1; a1 = 4'd1;
    cycle();
    chk("load_idx", 32'(idx0), 32'd1);
    chk("load_nowrap", 32'(wrap0), 32'd0);
    load = 1'b0;
    cycle(); cycle(); cycle();
    chk("down_0", 32'(idx0), 32'd0);
    cycle(); cycle(); cycle();
    chk("down_7", 32'(idx0), 32'd7);
    chk("down_wrap", 32'(wrap0), 32'd1);
    cycle(); cycle(); cycle();
    chk("down_6", 32'(idx0), 32'd6);
    chk("down_6_nowrap", 32'(wrap0), 32'd0);

    // enable off/on mid-scan
    mode = 2'b01; tick_div = 16'd1;
    cycle(); cycle(); cycle();
    p = m_idx[0];
    en = 1'b0;
    cycle();
    chk("en0_blank", 32'(y0), 32'h0);
    chk("en0_blank_low", 32'(y1), 32'hFFFF);
    chk("en0_frozen", 32'(idx0), 32'(p));
    cycle(); cycle(); cycle();
    chk("en0_still", 32'(idx0), 32'(p));
    en = 1'b1;
    cycle();
    chk("en1_restore", 32'(y0), 32'h1 << p);

    // hold for 20 cycles
    mode = 2'b11;
    cycle();
    p = m_idx[0];
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("hold_y", 32'(y0), 32'h1 << p);
    end

    // divider shrunk mid-count
    mode = 2'b01; tick_div = 16'd10;
    cycle();
    for (int i = 0; i < 15 && m_cnt[0] != 6; i++) cycle();
    p = m_idx[0];
    tick_div = 16'd3;
    cycle();
    chk("div_step_now", 32'(idx0), 32'((p + 1) % 8));
    cycle(); cycle(); cycle();
    chk("div_wait", 32'(idx0), 32'((p + 1) % 8));
    cycle();
    chk("div_step4", 32'(idx0), 32'((p + 2) % 8));

    // active-low instance direct + reset
    mode = 2'b00; a1 = 4'd9; a0 = 3'd2;
    cycle();
    chk("al_direct", 32'(y1), 32'hFDFF);
    async_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 7) != 0);
      a0       = 3'($urandom);
      a1       = 4'($urandom);
      if ($urandom_range(0, 9) == 0) tick_div = 16'($urandom_range(0, 4));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
